// File: rtl/mips_load_pkg.sv
// Shared encodings for the MEM-stage load path: ReqOp codes, FSM states, lane widths.
// LOAD_UNALIGNED_EN makes LWL/LWR legal; without it they take the error path.
package mips_load_pkg;

    typedef enum logic [2:0] {
        OP_LB   = 3'b000,
        OP_LH   = 3'b001,
        OP_LWL  = 3'b010,
        OP_LW   = 3'b011,
        OP_LBU  = 3'b100,
        OP_LHU  = 3'b101,
        OP_LWR  = 3'b110,
        OP_RSVD = 3'b111
    } loadOpT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lruStateT;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // k is the byte offset inside the addressed word
    function automatic logic opLegal(input loadOpT op, input logic [1:0] k);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_LB, OP_LBU: legal = 1'b1;
            OP_LH, OP_LHU: legal = ~k[0];
            OP_LW:         legal = (k == 2'b00);
`ifdef LOAD_UNALIGNED_EN
            OP_LWL, OP_LWR: legal = 1'b1;
`else
            OP_LWL, OP_LWR: legal = 1'b0;
`endif
            default:       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Combinational lane select and sign/zero extension of a loaded word, plus LWL/LWR merge.
// Also consumed by the forwarding logic, so it stays purely combinational.
module load_lane_extract
    import mips_load_pkg::*;
(
    input  logic [WORD_W-1:0] Word,
    input  logic [1:0]        K,
    input  loadOpT            Op,
    input  logic [WORD_W-1:0] RegOld,
    output logic [WORD_W-1:0] Result
);

    logic [BYTE_W-1:0] laneByte;
    logic [HALF_W-1:0] laneHalf;
    logic [4:0]        shL;
    logic [4:0]        shR;

    always_comb begin
        laneByte = Word[{K, 3'b000} +: BYTE_W];
        laneHalf = K[1] ? Word[31:16] : Word[15:0];
        shL      = {2'd3 - K, 3'b000};
        shR      = {K, 3'b000};
        Result   = '0;
        case (Op)
            OP_LB:   Result = {{24{laneByte[7]}}, laneByte};
            OP_LBU:  Result = {24'd0, laneByte};
            OP_LH:   Result = {{16{laneHalf[15]}}, laneHalf};
            OP_LHU:  Result = {16'd0, laneHalf};
            OP_LW:   Result = Word;
            OP_LWL:  Result = (Word << shL) | (RegOld & ~(32'hFFFF_FFFF << shL));
            OP_LWR:  Result = (Word >> shR) | (RegOld & ~(32'hFFFF_FFFF >> shR));
            default: Result = '0;
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// MEM-stage load reader: one outstanding word read, timeout guard, one-cycle result strobe.
// LOAD_UNALIGNED_EN (see mips_load_pkg) enables LWL/LWR.
module load_read_unit
    import mips_load_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [2:0]        ReqOp,
    input  logic [4:0]        ReqDest,
    input  logic [DATA_W-1:0] RegOld,
    output logic              MemRdEn,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic              MemRdValid,
    output logic              LoadValid,
    output logic [DATA_W-1:0] LoadData,
    output logic [4:0]        LoadDest,
    output logic              LoadErr
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    lruStateT          state, stateNext;
    logic [7:0]        timer;
    logic [1:0]        kQ;
    loadOpT            opQ;
    logic [4:0]        destQ;
    logic [DATA_W-1:0] regOldQ;
    logic [DATA_W-1:0] extData;
    logic              reqFire, reqLegal, dataHit, timeoutHit;

    assign ReqReady   = (state == IDLE);
    assign reqFire    = ReqValid && ReqReady;
    assign reqLegal   = opLegal(loadOpT'(ReqOp), ReqAddr[1:0]);
    // MemRdEn marks the first WAIT cycle; a response there is too early to be ours
    assign dataHit    = (state == WAIT) && MemRdValid && !MemRdEn;
    assign timeoutHit = (state == WAIT) && (timer == TIMER_LAST);

    load_lane_extract uExtract (
        .Word   (MemRdData),
        .K      (kQ),
        .Op     (opQ),
        .RegOld (regOldQ),
        .Result (extData)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (reqFire) stateNext = reqLegal ? WAIT : RESP;
            WAIT:    if (dataHit || timeoutHit) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            timer     <= '0;
            kQ        <= '0;
            opQ       <= OP_LB;
            destQ     <= '0;
            regOldQ   <= '0;
            MemRdEn   <= 1'b0;
            MemAddr   <= '0;
            LoadValid <= 1'b0;
            LoadData  <= '0;
            LoadDest  <= '0;
            LoadErr   <= 1'b0;
        end else begin
            state     <= stateNext;
            MemRdEn   <= 1'b0;
            LoadValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqFire && reqLegal) begin
                        kQ      <= ReqAddr[1:0];
                        opQ     <= loadOpT'(ReqOp);
                        destQ   <= ReqDest;
                        regOldQ <= RegOld;
                        timer   <= '0;
                        MemRdEn <= 1'b1;
                        MemAddr <= {ReqAddr[ADDR_W-1:2], 2'b00};
                    end else if (reqFire) begin
                        LoadValid <= 1'b1;
                        LoadErr   <= 1'b1;
                        LoadData  <= '0;
                        LoadDest  <= ReqDest;
                    end
                end
                WAIT: begin
                    if (dataHit) begin
                        LoadValid <= 1'b1;
                        LoadErr   <= 1'b0;
                        LoadData  <= extData;
                        LoadDest  <= destQ;
                    end else if (timeoutHit) begin
                        LoadValid <= 1'b1;
                        LoadErr   <= 1'b1;
                        LoadData  <= '0;
                        LoadDest  <= destQ;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
